// File: rtl/stopwatch_time_keeper_pkg.sv
// Shared constants for the stopwatch time keeper: BCD limits, default prescale and digit packing.
// Digit indices count from the least significant nibble of the 24-bit time word.
package stopwatch_pkg;
  localparam logic [3:0] BCD_MAX_UNITS   = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_60 = 4'd5;
  localparam int unsigned TICK_DIV_50MHZ = 500000;

  localparam int DIGIT_W    = 4;
  localparam int TIME_W     = 24;
  localparam int PRESCALE_W = 30;

  localparam int DIG_CS_U  = 0;
  localparam int DIG_CS_T  = 1;
  localparam int DIG_SEC_U = 2;
  localparam int DIG_SEC_T = 3;
  localparam int DIG_MIN_U = 4;
  localparam int DIG_MIN_T = 5;
endpackage

// File: rtl/stopwatch_time_keeper_if.sv
// Control flags from the watch state machine and time outputs toward the display mux.
// master = control/display side, slave = time keeper.
interface stopwatch_time_keeper_if;
  import stopwatch_pkg::*;

  logic                run_flag;
  logic                lap_flag;
  logic                reset_fast_flag;
  logic [TIME_W-1:0]   live_time;
  logic [TIME_W-1:0]   display_time;
  logic [DIGIT_W-1:0]  hours;
  logic                tick;
  logic                wrap;

  modport master (
    output run_flag, lap_flag, reset_fast_flag,
    input  live_time, display_time, hours, tick, wrap
  );

  modport slave (
    input  run_flag, lap_flag, reset_fast_flag,
    output live_time, display_time, hours, tick, wrap
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that wraps to 0 after reaching limit; value updates one cycle after enable.
// carry is combinational so a whole digit chain advances in the same cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] value,
  output logic               carry
);
  logic [DIGIT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == limit) ? '0 : cnt_q + DIGIT_W'(1);
    end
  end

  assign value = cnt_q;
  assign carry = enable && (cnt_q == limit);
endmodule

// File: rtl/stopwatch_time_keeper.sv
// BCD mm:ss.cc stopwatch counter with lap-freezable display copy; tick/wrap/live_time are registered.
// Optional hours digit is built when STOPWATCH_HOURS_EN is defined.
module stopwatch_time_keeper
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_50MHZ
)(
  input  logic                   qzt_clk,
  input  logic                   reset_n,
  stopwatch_time_keeper_if.slave sw
);
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick_now;
  logic                  wrap_now;
  logic                  tick_q;
  logic                  wrap_q;
  logic [TIME_W-1:0]     live_time;
  logic [TIME_W-1:0]     display_q;

  logic [DIGIT_W-1:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
  logic               c_cs_u, c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;

  // Fast reset masks the tick so no digit, tick or wrap can move in a clear cycle.
  assign tick_now = sw.run_flag && !sw.reset_fast_flag && (prescale_q == TICK_LAST);

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
    end else if (sw.reset_fast_flag) begin
      prescale_q <= '0;
    end else if (sw.run_flag) begin
      prescale_q <= tick_now ? '0 : prescale_q + PRESCALE_W'(1);
    end
  end

  bcd_digit_counter u_cs_u (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(tick_now), .limit(BCD_MAX_UNITS), .value(cs_u), .carry(c_cs_u));
  bcd_digit_counter u_cs_t (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_cs_u), .limit(BCD_MAX_UNITS), .value(cs_t), .carry(c_cs_t));
  bcd_digit_counter u_sec_u (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_cs_t), .limit(BCD_MAX_UNITS), .value(sec_u), .carry(c_sec_u));
  bcd_digit_counter u_sec_t (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_sec_u), .limit(BCD_MAX_TENS_60), .value(sec_t), .carry(c_sec_t));
  bcd_digit_counter u_min_u (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_sec_t), .limit(BCD_MAX_UNITS), .value(min_u), .carry(c_min_u));
  bcd_digit_counter u_min_t (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_min_u), .limit(BCD_MAX_TENS_60), .value(min_t), .carry(c_min_t));

`ifdef STOPWATCH_HOURS_EN
  logic [DIGIT_W-1:0] hr;
  logic               c_hr;

  bcd_digit_counter u_hr (.clock(qzt_clk), .reset_n(reset_n), .clear(sw.reset_fast_flag),
    .enable(c_min_t), .limit(BCD_MAX_UNITS), .value(hr), .carry(c_hr));

  assign wrap_now = c_hr;
  assign sw.hours = hr;
`else
  assign wrap_now = c_min_t;
  assign sw.hours = 4'h0;
`endif

  always_comb begin
    live_time = '0;
    live_time[DIG_CS_U*DIGIT_W  +: DIGIT_W] = cs_u;
    live_time[DIG_CS_T*DIGIT_W  +: DIGIT_W] = cs_t;
    live_time[DIG_SEC_U*DIGIT_W +: DIGIT_W] = sec_u;
    live_time[DIG_SEC_T*DIGIT_W +: DIGIT_W] = sec_t;
    live_time[DIG_MIN_U*DIGIT_W +: DIGIT_W] = min_u;
    live_time[DIG_MIN_T*DIGIT_W +: DIGIT_W] = min_t;
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      display_q <= '0;
    end else begin
      tick_q <= tick_now;
      wrap_q <= wrap_now;
      if (sw.reset_fast_flag) begin
        display_q <= '0;
      end else if (!sw.lap_flag) begin
        display_q <= live_time;
      end
    end
  end

  assign sw.live_time    = live_time;
  assign sw.display_time = display_q;
  assign sw.tick         = tick_q;
  assign sw.wrap         = wrap_q;
endmodule

// File: tb/tb_stopwatch_time_keeper.sv
// Bench for stopwatch_time_keeper with TICK_DIV=4: centisecond-count model feeds a scoreboard
// checked every cycle, plus fixed-value checks at the interesting points.
module tb_stopwatch_time_keeper;
  localparam int TICK_DIV = 4;
`ifdef STOPWATCH_HOURS_EN
  localparam int MOD = 3600000;
`else
  localparam int MOD = 360000;
`endif

  typedef struct {
    logic [23:0] live;
    logic [23:0] disp;
    logic [3:0]  hrs;
    logic        tk;
    logic        wr;
  } exp_t;

  logic qzt_clk;
  logic reset_n;
  stopwatch_time_keeper_if sw();

  stopwatch_time_keeper #(.TICK_DIV(TICK_DIV)) dut (
    .qzt_clk (qzt_clk),
    .reset_n (reset_n),
    .sw      (sw)
  );

  exp_t        sb_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          m_pre   = 0;
  int          m_total = 0;
  logic [23:0] m_disp  = '0;
  logic        m_tick  = 1'b0;
  logic        m_wrap  = 1'b0;
  logic [23:0] pl_bcd;
`ifdef STOPWATCH_HOURS_EN
  logic [3:0]  pl_hr;
`endif

  initial begin
    qzt_clk = 1'b0;
    forever #5 qzt_clk = ~qzt_clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int t);
    int mn, sc, cs;
    mn = (t / 6000) % 60;
    sc = (t / 100) % 60;
    cs = t % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic logic [3:0] to_hours(input int t);
`ifdef STOPWATCH_HOURS_EN
    return 4'(t / 360000);
`else
    return 4'(t * 0);
`endif
  endfunction

  // One clock cycle: drive at negedge, predict post-edge outputs, return after the edge.
  task automatic drive(input logic run, input logic lap, input logic fast);
    exp_t e;
    @(negedge qzt_clk);
    sw.run_flag        = run;
    sw.lap_flag        = lap;
    sw.reset_fast_flag = fast;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (fast) begin
      m_pre   = 0;
      m_total = 0;
      m_disp  = '0;
    end else begin
      if (!lap) m_disp = to_bcd(m_total);
      if (run) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre   = 0;
          m_total = (m_total + 1) % MOD;
          m_tick  = 1'b1;
          m_wrap  = (m_total == 0);
        end else begin
          m_pre++;
        end
      end
    end
    e.live = to_bcd(m_total);
    e.disp = m_disp;
    e.hrs  = to_hours(m_total);
    e.tk   = m_tick;
    e.wr   = m_wrap;
    sb_q.push_back(e);
    @(posedge qzt_clk);
    #2;
  endtask

  task automatic run_cycles(input int n, input logic run, input logic lap);
    for (int i = 0; i < n; i++) drive(run, lap, 1'b0);
  endtask

  task automatic preload(input int total);
    pl_bcd = to_bcd(total);
    force dut.u_cs_u.cnt_q  = pl_bcd[3:0];
    force dut.u_cs_t.cnt_q  = pl_bcd[7:4];
    force dut.u_sec_u.cnt_q = pl_bcd[11:8];
    force dut.u_sec_t.cnt_q = pl_bcd[15:12];
    force dut.u_min_u.cnt_q = pl_bcd[19:16];
    force dut.u_min_t.cnt_q = pl_bcd[23:20];
`ifdef STOPWATCH_HOURS_EN
    pl_hr = to_hours(total);
    force dut.u_hr.cnt_q = pl_hr;
`endif
    m_total = total;
  endtask

  task automatic unload();
    release dut.u_cs_u.cnt_q;
    release dut.u_cs_t.cnt_q;
    release dut.u_sec_u.cnt_q;
    release dut.u_sec_t.cnt_q;
    release dut.u_min_u.cnt_q;
    release dut.u_min_t.cnt_q;
`ifdef STOPWATCH_HOURS_EN
    release dut.u_hr.cnt_q;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_live"}, 32'(sw.live_time), 32'h0);
    check_val({tag, "_disp"}, 32'(sw.display_time), 32'h0);
    check_val({tag, "_hours"}, 32'(sw.hours), 32'h0);
    check_val({tag, "_tick"}, 32'(sw.tick), 32'h0);
    check_val({tag, "_wrap"}, 32'(sw.wrap), 32'h0);
  endtask

  // Scoreboard monitor: every predicted cycle is compared one step after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge qzt_clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val("sb_live", 32'(sw.live_time), 32'(e.live));
        check_val("sb_disp", 32'(sw.display_time), 32'(e.disp));
        check_val("sb_hours", 32'(sw.hours), 32'(e.hrs));
        check_val("sb_tick", 32'(sw.tick), 32'(e.tk));
        check_val("sb_wrap", 32'(sw.wrap), 32'(e.wr));
      end
    end
  end

  initial begin
    reset_n            = 1'b0;
    sw.run_flag        = 1'b0;
    sw.lap_flag        = 1'b0;
    sw.reset_fast_flag = 1'b0;
    repeat (3) @(negedge qzt_clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Asynchronous reset in the middle of counting, then first tick latency.
    run_cycles(10, 1'b1, 1'b0);
    check_val("precount_live", 32'(sw.live_time), 32'h000002);
    @(negedge qzt_clk);
    reset_n     = 1'b0;
    sw.run_flag = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_pre = 0; m_total = 0; m_disp = '0;
    @(negedge qzt_clk);
    reset_n = 1'b1;
    run_cycles(3, 1'b1, 1'b0);
    check_val("first_tick_early", 32'(sw.tick), 32'h0);
    drive(1'b1, 1'b0, 1'b0);
    check_val("first_tick", 32'(sw.tick), 32'h1);
    check_val("first_tick_live", 32'(sw.live_time), 32'h000001);

    // 100 ticks: seconds carry lands exactly on the 100th.
    drive(1'b0, 1'b0, 1'b1);
    run_cycles(399, 1'b1, 1'b0);
    check_val("tick99_live", 32'(sw.live_time), 32'h000099);
    drive(1'b1, 1'b0, 1'b0);
    check_val("tick100_live", 32'(sw.live_time), 32'h000100);

    // Pause keeps the fractional centisecond.
    drive(1'b0, 1'b0, 1'b1);
    run_cycles(6, 1'b1, 1'b0);
    run_cycles(20, 1'b0, 1'b0);
    check_val("pause_live", 32'(sw.live_time), 32'h000001);
    drive(1'b1, 1'b0, 1'b0);
    check_val("resume1_tick", 32'(sw.tick), 32'h0);
    drive(1'b1, 1'b0, 1'b0);
    check_val("resume2_tick", 32'(sw.tick), 32'h1);
    check_val("resume2_live", 32'(sw.live_time), 32'h000002);

    // Lap freeze and resume.
    drive(1'b0, 1'b0, 1'b1);
    run_cycles(21, 1'b1, 1'b0);
    check_val("lap_start_disp", 32'(sw.display_time), 32'h000005);
    run_cycles(39, 1'b1, 1'b1);
    check_val("lap_disp", 32'(sw.display_time), 32'h000005);
    check_val("lap_live", 32'(sw.live_time), 32'h000015);
    drive(1'b0, 1'b0, 1'b0);
    check_val("lap_end_disp", 32'(sw.display_time), 32'h000015);

    // Fast reset colliding with a tick while lap is held.
    drive(1'b0, 1'b0, 1'b1);
    run_cycles(7, 1'b1, 1'b0);
    check_val("pre_fast_disp", 32'(sw.display_time), 32'h000001);
    drive(1'b1, 1'b1, 1'b1);
    check_all_zero("fast_on_tick");
    run_cycles(3, 1'b1, 1'b0);
    check_val("post_fast_early", 32'(sw.tick), 32'h0);
    drive(1'b1, 1'b0, 1'b0);
    check_val("post_fast_tick", 32'(sw.tick), 32'h1);

    // Rollover from 59:59.99.
    drive(1'b0, 1'b0, 1'b1);
    preload(359999);
    drive(1'b0, 1'b0, 1'b0);
    unload();
    run_cycles(3, 1'b1, 1'b0);
    check_val("max_live", 32'(sw.live_time), 32'h595999);
    drive(1'b1, 1'b0, 1'b0);
    check_val("roll_live", 32'(sw.live_time), 32'h000000);
`ifdef STOPWATCH_HOURS_EN
    check_val("roll_hours", 32'(sw.hours), 32'h1);
    check_val("roll_wrap", 32'(sw.wrap), 32'h0);
    drive(1'b0, 1'b0, 1'b1);
    preload(3599999);
    drive(1'b0, 1'b0, 1'b0);
    unload();
    run_cycles(3, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check_val("hroll_live", 32'(sw.live_time), 32'h000000);
    check_val("hroll_hours", 32'(sw.hours), 32'h0);
    check_val("hroll_wrap", 32'(sw.wrap), 32'h1);
`else
    check_val("roll_wrap", 32'(sw.wrap), 32'h1);
`endif
    drive(1'b1, 1'b0, 1'b0);
    check_val("wrap_single", 32'(sw.wrap), 32'h0);

    check_val("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
